// File: rtl/fifo_bit_packer_if.sv
// Narrow input stream plus async-FIFO write port of the bit packer.
// master drives beats and the full flag; slave is the packer itself.
interface fifo_bit_packer_if #(
    parameter int IN_WIDTH = 1,
    parameter int RATIO    = 4
);
    localparam int OUT_WIDTH = IN_WIDTH * RATIO;

    logic                 s_valid;
    logic                 s_ready;
    logic [IN_WIDTH-1:0]  s_data;
    logic                 s_last;
    logic                 fifo_w_en;
    logic [OUT_WIDTH-1:0] fifo_dat;
    logic                 fifo_full;

    modport master (
        output s_valid, s_data, s_last, fifo_full,
        input  s_ready, fifo_w_en, fifo_dat
    );

    modport slave (
        input  s_valid, s_data, s_last, fifo_full,
        output s_ready, fifo_w_en, fifo_dat
    );
endinterface

// File: rtl/fifo_bit_packer.sv
// Packs RATIO narrow beats into one FIFO word held in a one-entry output register.
// Define PACKER_STALL_CNT_EN to add the saturating stall_cnt output.
module fifo_bit_packer #(
    parameter int IN_WIDTH = 1,
    parameter int RATIO    = 4,
    parameter int CNT_W    = $clog2(RATIO)
) (
    input  logic          w_clk,
    input  logic          r_rst,
    fifo_bit_packer_if.slave bus,
`ifdef PACKER_STALL_CNT_EN
    output logic [15:0]   stall_cnt,
`endif
    output logic [15:0]   word_cnt
);
    localparam int               OUT_WIDTH = IN_WIDTH * RATIO;
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATIO - 1);

    logic [CNT_W-1:0]     cnt;
    logic [OUT_WIDTH-1:0] acc;
    logic [OUT_WIDTH-1:0] lane_word;
    logic [OUT_WIDTH-1:0] hold_dat;
    logic                 hold_valid;
    logic                 last_lane;
    logic                 beat;
    logic                 complete;
    logic                 drain;

    assign last_lane     = (cnt == LAST_LANE);
    assign drain         = hold_valid && !bus.fifo_full;
    // A completing beat needs the hold register free, either empty or draining now.
    assign bus.s_ready   = !hold_valid || !bus.fifo_full || (!last_lane && !bus.s_last);
    assign beat          = bus.s_valid && bus.s_ready;
    assign complete      = beat && (last_lane || bus.s_last);
    assign bus.fifo_w_en = drain;
    assign bus.fifo_dat  = hold_dat;

    always_comb begin
        lane_word = '0;
        lane_word[32'(cnt) * IN_WIDTH +: IN_WIDTH] = bus.s_data;
    end

    always_ff @(posedge w_clk or posedge r_rst) begin
        if (r_rst) begin
            cnt <= '0;
            acc <= '0;
        end else if (beat) begin
            if (complete) begin
                cnt <= '0;
                acc <= '0;
            end else begin
                cnt <= cnt + 1'b1;
                acc <= acc | lane_word;
            end
        end
    end

    // Lanes above cnt are always zero in acc, so OR-ing in the current lane pads early words.
    always_ff @(posedge w_clk or posedge r_rst) begin
        if (r_rst) begin
            hold_valid <= 1'b0;
            hold_dat   <= '0;
        end else if (complete) begin
            hold_valid <= 1'b1;
            hold_dat   <= acc | lane_word;
        end else if (drain) begin
            hold_valid <= 1'b0;
        end
    end

    always_ff @(posedge w_clk or posedge r_rst) begin
        if (r_rst) begin
            word_cnt <= '0;
        end else if (drain) begin
            word_cnt <= word_cnt + 16'd1;
        end
    end

`ifdef PACKER_STALL_CNT_EN
    always_ff @(posedge w_clk or posedge r_rst) begin
        if (r_rst) begin
            stall_cnt <= '0;
        end else if (bus.s_valid && !bus.s_ready && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif
endmodule
